// File: rtl/bmac_pkg.sv
// Shared definitions for the BMAC datapath: default widths and the
// accumulator FSM state encoding.
package bmac_pkg;

    // Default widths used across the BMAC stages.
    localparam int BMAC_IN_WIDTH  = 32;
    localparam int BMAC_OUT_WIDTH = 16;
    localparam int ACC_WIDTH      = 32;

    // Accumulator FSM encoding; the fourth code is unused and recovers to idle.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage : bmac_pkg

// File: rtl/bmac_sat_add.sv
// Combinational signed saturating adder. The sum is formed one bit wider
// than the operands, and results outside the WIDTH-bit signed range
// clamp to the nearest limit, raising the overflow flag.
module bmac_sat_add
    import bmac_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH:0] wide;

    // Widen, add, then clamp when the two top bits of the wide sum disagree.
    always_comb begin
        // NOTE: every output is assigned at the top of the block before any
        // conditional override, so no path leaves a value unassigned and no
        // latch can be inferred; combinational logic uses blocking '='.
        wide     = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        overflow = wide[WIDTH] ^ wide[WIDTH-1];
        sum      = wide[WIDTH-1:0];
        if (overflow) begin
            // The extra top bit carries the true sign of the unclamped sum.
            sum = wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule : bmac_sat_add

// File: rtl/bmac_acc.sv
// Accumulation stage behind BMAC: sums len_in consecutive signed partials
// into one saturated ACC_WIDTH result and hands it downstream over a
// valid/ready handshake. Handshake outputs decode from registered state only.
module bmac_acc
    import bmac_pkg::*;
#(
    parameter int IN_WIDTH  = BMAC_OUT_WIDTH,
    parameter int ACC_WIDTH = bmac_pkg::ACC_WIDTH,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN_WIDTH-1:0] len_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat
);

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] acc;
    logic                 sat;
    logic [LEN_WIDTH-1:0] rem;

    logic                 beat;
    logic                 take;
    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic                 ovf;

    // Accept while collecting, present while holding; never both at once.
    assign in_ready  = (state != ST_HOLD);
    assign out_valid = (state == ST_HOLD);
    assign beat      = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    // Partials are two's complement, so widen by sign extension.
    assign in_ext = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

    bmac_sat_add #(
        .WIDTH(ACC_WIDTH)
    ) u_sat_add (
        .a       (acc),
        .b       (in_ext),
        .sum     (sum),
        .overflow(ovf)
    );

    // acc only changes in IDLE/ACC, so it can drive the output directly.
    assign out_data = acc;
    assign out_sat  = sat;

    // FSM, beat counter and accumulator; reset aborts any partial result.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking '<=' so every register in
        // this block updates from the same pre-edge values.
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            sat   <= 1'b0;
            rem   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (beat) begin
                        // The first beat cannot overflow because ACC_WIDTH > IN_WIDTH.
                        acc <= in_ext;
                        sat <= 1'b0;
                        rem <= len_in - LEN_WIDTH'(1);
                        // A length of zero is treated as a single-beat result.
                        state <= (len_in <= LEN_WIDTH'(1)) ? ST_HOLD : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (beat) begin
                        acc <= sum;
                        sat <= sat | ovf;
                        rem <= rem - LEN_WIDTH'(1);
                        if (rem == LEN_WIDTH'(1)) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (take) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : bmac_acc

// File: tb/tb_bmac_acc.sv
// Self-checking bench for bmac_acc: table-driven results with a scoreboard
// queue, a randomised sweep against a small reference model, and directed
// sequences for reset abort and saturation (17-bit accumulator instance).
module tb_bmac_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  len_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;

    // Second instance with a narrow accumulator to exercise saturation.
    logic [7:0]  s_len_in;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [16:0] s_out_data;
    logic        s_out_sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        sat;
    } res_t;

    typedef struct {
        int          len;
        int          nb;
        logic [15:0] b [8];
        int          bubble;
        int          stall;
        logic [31:0] ed;
        logic        es;
    } vec_t;

    res_t sb [$];
    res_t exp_res;
    vec_t vt [5];

    always #5 clk = ~clk;

    bmac_acc dut (
        .clk      (clk),
        .rst      (rst),
        .len_in   (len_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    bmac_acc #(
        .IN_WIDTH (16),
        .ACC_WIDTH(17),
        .LEN_WIDTH(8)
    ) dut17 (
        .clk      (clk),
        .rst      (rst),
        .len_in   (s_len_in),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_data  (s_in_data),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_data (s_out_data),
        .out_sat  (s_out_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: running signed sum clamped to the 32-bit range after each beat.
    function automatic logic [31:0] model(input int n, input logic [15:0] b [8]);
        longint a  = 0;
        longint mx = 64'sh7FFF_FFFF;
        longint mn = -64'sh8000_0000;
        for (int i = 0; i < n; i++) begin
            a += longint'($signed(b[i]));
            if (a > mx) a = mx;
            if (a < mn) a = mn;
        end
        return a[31:0];
    endfunction

    function automatic vec_t mk(input int len, input int nb,
                                input logic [15:0] b0, input logic [15:0] b1,
                                input logic [15:0] b2, input logic [15:0] b3,
                                input logic [15:0] b4, input int bubble, input int stall,
                                input logic [31:0] ed, input logic es);
        vec_t v;
        v.len = len; v.nb = nb; v.bubble = bubble; v.stall = stall;
        v.ed = ed; v.es = es;
        for (int i = 0; i < 8; i++) v.b[i] = 16'h0;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
        return v;
    endfunction

    // Monitor: handshake legality, output stability in HOLD, scoreboard pops.
    logic [31:0] held_data;
    logic        held_sat;
    bit          was_holding = 0;
    always @(negedge clk) begin
        if (rst) begin
            was_holding = 0;
        end else if (out_valid) begin
            check("in_ready_low_in_hold", {31'b0, in_ready}, 32'd0);
            if (was_holding) begin
                check("hold_data_stable", out_data, held_data);
                check("hold_sat_stable", {31'b0, out_sat}, {31'b0, held_sat});
            end
            held_data   = out_data;
            held_sat    = out_sat;
            was_holding = 1;
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h expected no result", out_data);
                end else begin
                    exp_res = sb.pop_front();
                    check("result_data", out_data, exp_res.data);
                    check("result_sat", {31'b0, out_sat}, {31'b0, exp_res.sat});
                end
                was_holding = 0;
            end
        end else begin
            was_holding = 0;
        end
    end

    // Drive one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [15:0] d);
        int waited = 0;
        bit done   = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_accept_timeout: got in_ready 0 expected 1");
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    // One full result: push expectation, drive beats with bubbles, optional stall.
    task automatic send_result(input int len, input int nb, input logic [15:0] b [8],
                               input int bubble, input int stall,
                               input logic [31:0] ed, input logic es);
        res_t r;
        r.data = ed;
        r.sat  = es;
        sb.push_back(r);
        out_ready = (stall == 0);
        len_in    = len[7:0];
        for (int i = 0; i < nb; i++) begin
            send_beat(b[i]);
            len_in = 8'hFF;  // changes after the first beat must be ignored
            if (i < nb - 1) begin
                repeat (bubble) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(negedge clk);
        check("latency_out_valid", {31'b0, out_valid}, 32'd1);
        if (stall > 0) begin
            repeat (stall - 1) @(negedge clk);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] rb [8];
        int          rlen;
        int          budget;

        rst = 1'b1; len_in = 8'd0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1;
        s_len_in = 8'd0; s_in_valid = 1'b0; s_in_data = 16'h0; s_out_ready = 1'b1;

        vt[0] = mk(4, 4, 16'h0003, 16'hFFFE, 16'h0010, 16'h0001, 16'h0, 0, 0, 32'h0000_0012, 1'b0);
        vt[1] = mk(3, 3, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 1, 5, 32'h0001_7FFD, 1'b0);
        vt[2] = mk(0, 1, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 32'hFFFF_8000, 1'b0);
        vt[3] = mk(1, 1, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 32'hFFFF_8000, 1'b0);
        vt[4] = mk(5, 5, 16'h1234, 16'hFFFF, 16'h0100, 16'h8001, 16'h0002, 2, 0, 32'hFFFF_9336, 1'b0);

        // Reset for one cycle, then confirm idle outputs on both instances.
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_sat", {31'b0, out_sat}, 32'd0);
        check("reset17_in_ready", {31'b0, s_in_ready}, 32'd1);
        check("reset17_out_data", {15'b0, s_out_data}, 32'd0);
        repeat (3) @(negedge clk);
        check("idle_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Table-driven results.
        for (int i = 0; i < 5; i++) begin
            send_result(vt[i].len, vt[i].nb, vt[i].b, vt[i].bubble, vt[i].stall,
                        vt[i].ed, vt[i].es);
        end

        // Randomised results against the reference model.
        for (int k = 0; k < 6; k++) begin
            rlen = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) rb[i] = 16'($urandom);
            send_result(rlen, rlen, rb, $urandom_range(0, 2), $urandom_range(0, 2),
                        model(rlen, rb), 1'b0);
        end

        // Abort: two beats of a 4-beat result, reset, then a fresh 2-beat result.
        len_in = 8'd4;
        send_beat(16'h0001);
        send_beat(16'h0002);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_acc_cleared", out_data, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) rb[i] = 16'h0;
        rb[0] = 16'h0005;
        rb[1] = 16'h0006;
        send_result(2, 2, rb, 0, 0, 32'd11, 1'b0);

        // Saturation on the 17-bit instance, then a clean result clears the flag.
        s_len_in = 8'd3;
        for (int i = 0; i < 3; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = 16'h7FFF;
            @(negedge clk);
            check("sat17_in_ready", {31'b0, s_in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        @(negedge clk);
        check("sat17_out_valid", {31'b0, s_out_valid}, 32'd1);
        check("sat17_out_data", {15'b0, s_out_data}, 32'h0000_FFFF);
        check("sat17_out_sat", {31'b0, s_out_sat}, 32'd1);
        @(posedge clk);
        #1;
        s_len_in   = 8'd1;
        s_in_valid = 1'b1;
        s_in_data  = 16'h0001;
        @(negedge clk);
        check("sat17_next_in_ready", {31'b0, s_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check("sat17_next_out_valid", {31'b0, s_out_valid}, 32'd1);
        check("sat17_next_out_data", {15'b0, s_out_data}, 32'd1);
        check("sat17_next_out_sat", {31'b0, s_out_sat}, 32'd0);
        @(posedge clk);
        #1;

        // Drain: every pushed expectation must have been matched.
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bmac_acc

// File: doc/bmac_acc.md
# bmac_acc

Downstream accumulation stage for `BMAC`. Each `bmac_out` word is one partial dot product over 8 packed 4-bit lanes. `bmac_acc` sums a programmable number of consecutive partials into one wide result. It applies signed saturation and presents the result over a valid/ready handshake to the next layer stage.

## Interface

Parameters:
- `IN_WIDTH`, 16, width of one partial; equals `BMAC` `OUTPUT_WIDTH`.
- `ACC_WIDTH`, 32, accumulator and result width; must be greater than `IN_WIDTH`.
- `LEN_WIDTH`, 8, width of the beat-count input.

Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `len_in`  in  `LEN_WIDTH`  partials per result; sampled only on the first beat of a result.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_data`  in  `IN_WIDTH`  partial from `BMAC`, signed two's complement.
- `out_valid`  out  1  result is available.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  `ACC_WIDTH`  accumulated signed result.
- `out_sat`  out  1  saturation occurred at least once during this result.

## Operation

- A beat is accepted when `in_valid && in_ready`. A result is taken when `out_valid && out_ready`.
- States:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - ACC: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- IDLE, beat accepted:
  - `acc` ← sign-extended `in_data`; `sat` ← 0.
  - `rem` ← `len_in` − 1.
  - If `len_in` ≤ 1, go to HOLD. Otherwise go to ACC.
- ACC, beat accepted:
  - `acc` ← sat_add(`acc`, sext(`in_data`)); `sat` ← `sat` | overflow; `rem` ← `rem` − 1.
  - If `rem` == 1, go to HOLD.
- ACC, no beat: hold all state. Bubbles are allowed between beats.
- HOLD: `out_data`=`acc`, `out_sat`=`sat`, both stable while `out_valid` is high. When the result is taken, go to IDLE.
- `len_in` = 0 behaves exactly like `len_in` = 1.
- Saturating add:
  - Compute the sum at `ACC_WIDTH`+1 bits.
  - If it exceeds 2^(`ACC_WIDTH`−1)−1, clamp to that maximum. If it is below −2^(`ACC_WIDTH`−1), clamp to that minimum.
  - On clamp, overflow = 1. Once clamped, later beats keep adding from the clamped value.
- `len_in` changes during ACC or HOLD are ignored.
- Reset in any state, including mid-accumulation or during HOLD:
  - Next state IDLE. `acc`, `rem` and `sat` are cleared to 0.
  - Any partial result is discarded; no output is produced for it.

## Timing

- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_sat`=0.
- `in_ready` and `out_valid` are decoded from registered state only. They have no combinational path from `in_valid` or `out_ready`.
- Latency: `out_valid` rises in the cycle after the last beat is accepted.
- Throughput: one result per N+1 cycles at best, where N = max(`len_in`, 1). HOLD always costs at least one cycle.
- The first beat of the next result is accepted no earlier than the cycle after the result is taken.
- Backpressure: `out_ready` may stay low indefinitely. Outputs stay frozen and no input is accepted.
- No beat is lost or double-counted across bubbles or backpressure.

## Structure

- Shared package `bmac_pkg`:
  - Default widths: `BMAC_IN_WIDTH`=32, `BMAC_OUT_WIDTH`=16, `ACC_WIDTH`=32.
  - State encoding constants `ST_IDLE`, `ST_ACC`, `ST_HOLD`.
- Sub-module `bmac_sat_add`:
  - Combinational signed saturating adder, parameterised by width.
  - Outputs: sum and overflow flag.
  - Reused later by the bias-add stage.
- Top level contains the FSM, `rem` counter, `acc` and `sat` registers.

## Test plan

- Reset then idle: outputs 0, `in_ready`=1. Assert `rst` for 1 cycle with `out_ready`=1 → no `out_valid`.
- `len_in`=4, beats 0x0003, 0xFFFE, 0x0010, 0x0001, back-to-back → `out_valid` one cycle after the 4th beat; `out_data`=0x00000012, `out_sat`=0.
- `len_in`=3, beats 0x7FFF each, with one-cycle bubbles between beats, `out_ready` low for 5 cycles → `out_data`=0x00017FFD held stable for all 5 cycles; `in_ready`=0 throughout HOLD.
- `len_in`=0, then `len_in`=1, each with beat 0x8000 → two results, each 0xFFFF8000, each after a single beat.
- Saturation with `ACC_WIDTH`=17, `len_in`=3, beats 0x7FFF ×3 → `out_data`=0x0FFFF (17-bit max), `out_sat`=1. Next result (`len_in`=1, 0x0001) → `out_data`=1, `out_sat`=0.
- `len_in`=4, two beats accepted, then `rst` for 1 cycle, then `len_in`=2 with beats 5 and 6 → `out_data`=11; the aborted result is never presented.
